// File: rtl/b_to_g_counter.sv
// Up/down binary counter with a registered Gray-code image, a parallel load,
// a one-cycle wrap pulse and a per-edge mask of the Gray bits that changed.
module b_to_g_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic [WIDTH-1:0] flip
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] r_flip;

    logic [WIDTH-1:0] w_step_bin;
    logic [WIDTH-1:0] w_step_gray;
    logic [WIDTH-1:0] w_load_gray;
    logic             w_step_wrap;

    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Wrap is judged on the current value so it also fires for a decrement out of zero.
    always_comb begin
        w_step_bin  = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
        w_step_gray = encode(w_step_bin);
        w_load_gray = encode(load_bin);
        w_step_wrap = up ? (&r_bin) : (~|r_bin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
            r_flip <= '0;
        end else if (load) begin
            r_bin  <= load_bin;
            r_gray <= w_load_gray;
            r_wrap <= 1'b0;
            r_flip <= r_gray ^ w_load_gray;
        end else if (en) begin
            r_bin  <= w_step_bin;
            r_gray <= w_step_gray;
            r_wrap <= w_step_wrap;
            r_flip <= r_gray ^ w_step_gray;
        end else begin
            r_wrap <= 1'b0;
            r_flip <= '0;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;
    assign flip = r_flip;

endmodule

// File: tb/tb_b_to_g_counter.sv
// Bench for b_to_g_counter: directed WIDTH=3 vectors, then a randomized run
// on WIDTH=3 and WIDTH=5 instances checked against a small behavioural model.
module tb_b_to_g_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, en3, up3, load3;
    logic [2:0] lb3, bin3, gray3, flip3;
    logic       wrap3;

    logic       rst5, en5, up5, load5;
    logic [4:0] lb5, bin5, gray5, flip5;
    logic       wrap5;

    int total = 0;
    int bad   = 0;

    // Expected {bin, gray, wrap, flip} for the directed WIDTH=3 steps.
    logic [9:0] exp_q[$];

    b_to_g_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3),
        .load_bin(lb3), .bin(bin3), .gray(gray3), .wrap(wrap3), .flip(flip3)
    );

    b_to_g_counter #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst5), .en(en5), .up(up5), .load(load5),
        .load_bin(lb5), .bin(bin5), .gray(gray5), .wrap(wrap5), .flip(flip5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step3(input string tag, input logic r, input logic e, input logic u,
                         input logic l, input logic [2:0] lb,
                         input logic [2:0] eb, input logic [2:0] eg,
                         input logic ew, input logic [2:0] ef);
        logic [9:0] x;
        rst3 = r; en3 = e; up3 = u; load3 = l; lb3 = lb;
        exp_q.push_back({eb, eg, ew, ef});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check({tag, ".bin"},  32'(bin3),  32'(x[9:7]));
        check({tag, ".gray"}, 32'(gray3), 32'(x[6:4]));
        check({tag, ".wrap"}, 32'(wrap3), 32'(x[3]));
        check({tag, ".flip"}, 32'(flip3), 32'(x[2:0]));
    endtask

    // Reference behaviour of one edge for a counter of width w (w <= 8).
    task automatic model(input int w, input logic r, input logic e, input logic u,
                         input logic l, input logic [7:0] lb,
                         inout logic [7:0] b, inout logic [7:0] g,
                         output logic wr, output logic [7:0] f);
        logic [7:0] mask, nb, ng;
        mask = 8'((9'd1 << w) - 9'd1);
        if (r) begin
            b = 8'd0; g = 8'd0; wr = 1'b0; f = 8'd0;
        end else if (l) begin
            nb = lb & mask;
            ng = nb ^ (nb >> 1);
            f = g ^ ng; wr = 1'b0; b = nb; g = ng;
        end else if (e) begin
            nb = (u ? b + 8'd1 : b - 8'd1) & mask;
            wr = u ? (b == mask) : (b == 8'd0);
            ng = nb ^ (nb >> 1);
            f = g ^ ng; b = nb; g = ng;
        end else begin
            wr = 1'b0; f = 8'd0;
        end
    endtask

    initial begin
        logic [7:0] mb3, mg3, mf3, mb5, mg5, mf5;
        logic       mw3, mw5;
        logic       counted3, counted5;

        rst3 = 1'b1; en3 = 1'b0; up3 = 1'b0; load3 = 1'b0; lb3 = 3'd0;
        rst5 = 1'b1; en5 = 1'b0; up5 = 1'b0; load5 = 1'b0; lb5 = 5'd0;

        // reset
        step3("rst", 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);

        // eight up steps through the full Gray cycle
        step3("up1", 0, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0, 3'b001);
        step3("up2", 0, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0, 3'b010);
        step3("up3", 0, 1, 1, 0, 3'd0, 3'd3, 3'b010, 0, 3'b001);
        step3("up4", 0, 1, 1, 0, 3'd0, 3'd4, 3'b110, 0, 3'b100);
        step3("up5", 0, 1, 1, 0, 3'd0, 3'd5, 3'b111, 0, 3'b001);
        step3("up6", 0, 1, 1, 0, 3'd0, 3'd6, 3'b101, 0, 3'b010);
        step3("up7", 0, 1, 1, 0, 3'd0, 3'd7, 3'b100, 0, 3'b001);
        step3("up8", 0, 1, 1, 0, 3'd0, 3'd0, 3'b000, 1, 3'b100);

        // down from reset wraps to all ones
        step3("rst2", 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);
        step3("dn1",  0, 1, 0, 0, 3'd0, 3'd7, 3'b100, 1, 3'b100);
        step3("dn2",  0, 1, 0, 0, 3'd0, 3'd6, 3'b101, 0, 3'b001);

        // parallel load and a step after it
        step3("rst3", 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);
        step3("ld5",  0, 0, 0, 1, 3'd5, 3'd5, 3'b111, 0, 3'b111);
        step3("ldup", 0, 1, 1, 0, 3'd0, 3'd6, 3'b101, 0, 3'b010);

        // load beats en, even when loading the wrap value
        step3("ld7en", 0, 1, 1, 1, 3'd7, 3'd7, 3'b100, 0, 3'b001);
        step3("wrapup", 0, 1, 1, 0, 3'd0, 3'd0, 3'b000, 1, 3'b100);

        // count to 3 then reset together with en, then hold
        step3("c1",   0, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0, 3'b001);
        step3("c2",   0, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0, 3'b010);
        step3("c3",   0, 1, 1, 0, 3'd0, 3'd3, 3'b010, 0, 3'b001);
        step3("rsten", 1, 1, 1, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);
        step3("hold1", 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);
        step3("hold2", 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0);

        // direction change, load of current value, hold after a change
        step3("d1",   0, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0, 3'b001);
        step3("d2",   0, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0, 3'b010);
        step3("d3",   0, 1, 1, 0, 3'd0, 3'd3, 3'b010, 0, 3'b001);
        step3("d4",   0, 1, 1, 0, 3'd0, 3'd4, 3'b110, 0, 3'b100);
        step3("dback", 0, 1, 0, 0, 3'd0, 3'd3, 3'b010, 0, 3'b100);
        step3("ldsame", 0, 1, 0, 1, 3'd3, 3'd3, 3'b010, 0, 3'b000);
        step3("ld0", 0, 0, 0, 1, 3'd0, 3'd0, 3'b000, 0, 3'b010);
        step3("hold3", 0, 0, 1, 0, 3'd6, 3'd0, 3'b000, 0, 3'b000);

        // randomized run on both widths, starting with a reset
        mb3 = 8'd0; mg3 = 8'd0; mb5 = 8'd0; mg5 = 8'd0;
        for (int i = 0; i < 500; i++) begin
            rst3  = (i == 0) || ($urandom_range(0, 49) == 0);
            load3 = ($urandom_range(0, 5) == 0);
            en3   = ($urandom_range(0, 3) != 0);
            up3   = 1'($urandom_range(0, 1));
            lb3   = 3'($urandom_range(0, 7));
            rst5  = (i == 0) || ($urandom_range(0, 49) == 0);
            load5 = ($urandom_range(0, 5) == 0);
            en5   = ($urandom_range(0, 3) != 0);
            up5   = 1'($urandom_range(0, 1));
            lb5   = 5'($urandom_range(0, 31));
            model(3, rst3, en3, up3, load3, {5'd0, lb3}, mb3, mg3, mw3, mf3);
            model(5, rst5, en5, up5, load5, {3'd0, lb5}, mb5, mg5, mw5, mf5);
            counted3 = !rst3 && !load3 && en3;
            counted5 = !rst5 && !load5 && en5;
            @(posedge clk);
            #1;
            check("r3.bin",  32'(bin3),  32'(mb3[2:0]));
            check("r3.gray", 32'(gray3), 32'(mg3[2:0]));
            check("r3.wrap", 32'(wrap3), 32'(mw3));
            check("r3.flip", 32'(flip3), 32'(mf3[2:0]));
            check("r5.bin",  32'(bin5),  32'(mb5[4:0]));
            check("r5.gray", 32'(gray5), 32'(mg5[4:0]));
            check("r5.wrap", 32'(wrap5), 32'(mw5));
            check("r5.flip", 32'(flip5), 32'(mf5[4:0]));
            if (counted3) check("r3.onehot", 32'($onehot(flip3)), 32'd1);
            if (counted5) check("r5.onehot", 32'($onehot(flip5)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
